// File: rtl/ysyx_25060170_bus_arbiter.sv
// Two-master memory port arbiter: IFU and LSU share one memory port with one
// transaction in flight, fair alternation on ties, and a timeout abort.
module ysyx_25060170_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_rsp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic OWN_LSU = 1'b0;
    localparam logic OWN_IFU = 1'b1;
    localparam logic       TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                ifu_vld_q, ifu_vld_d, ifu_err_q, ifu_err_d;
    logic                lsu_vld_q, lsu_vld_d, lsu_err_q, lsu_err_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

    logic                ifu_win, lsu_win, done, expire, fire, fire_err;
    logic [DATA_W-1:0]   fire_data;

    // On a tie, the requester that was not granted last time wins.
    assign ifu_win = ifu_req_valid && (!lsu_req_valid || last_q == OWN_LSU);
    assign lsu_win = lsu_req_valid && !ifu_win;
    assign done    = (state_q == S_RESP) && mem_rsp_valid;
    assign expire  = TO_EN && (state_q != S_IDLE) && (cnt_q == TO_LAST) && !done;

    assign ifu_req_ready = (state_q == S_IDLE) && ifu_win;
    assign lsu_req_ready = (state_q == S_IDLE) && lsu_win;
    assign mem_req_valid = (state_q == S_REQ);
    assign busy          = (state_q != S_IDLE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rsp_valid = ifu_vld_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign ifu_rsp_err   = ifu_err_q;
    assign lsu_rsp_valid = lsu_vld_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign lsu_rsp_err   = lsu_err_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_vld_d   = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        ifu_err_d   = ifu_err_q;
        lsu_vld_d   = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        lsu_err_d   = lsu_err_q;
        fire        = 1'b0;
        fire_err    = 1'b0;
        fire_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (ifu_win) begin
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OWN_IFU;
                    last_d  = OWN_IFU;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else if (lsu_win) begin
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    owner_d = OWN_LSU;
                    last_d  = OWN_LSU;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (expire) begin
                    fire     = 1'b1;
                    fire_err = 1'b1;
                    state_d  = S_IDLE;
                end else if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (done) begin
                    fire      = 1'b1;
                    fire_data = wen_q ? '0 : mem_rdata;
                    state_d   = S_IDLE;
                end else if (expire) begin
                    fire     = 1'b1;
                    fire_err = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            if (owner_q == OWN_IFU) begin
                ifu_vld_d   = 1'b1;
                ifu_rdata_d = fire_data;
                ifu_err_d   = fire_err;
            end else begin
                lsu_vld_d   = 1'b1;
                lsu_rdata_d = fire_data;
                lsu_err_d   = fire_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_LSU;
            last_q      <= OWN_LSU;
            cnt_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_vld_q   <= 1'b0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_vld_q   <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_vld_q   <= ifu_vld_d;
            ifu_rdata_q <= ifu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_vld_q   <= lsu_vld_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25060170_bus_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: vector table plus
// hand-written fairness, timeout, reset and stray-response sequences.
module tb_ysyx_25060170_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    ysyx_25060170_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_ifu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          rdy_dly;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
                 lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
                 mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, busy};
    endfunction

    task automatic wait_grant(output logic ok);
        int n = 0;
        #1;
        while (!(ifu_req_ready || lsu_req_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        ok = ifu_req_ready || lsu_req_ready;
    endtask

    task automatic run_vec(input vec_t v);
        logic ok;
        @(negedge clk);
        if (v.is_ifu) begin
            ifu_req_valid = 1'b1; ifu_addr = v.addr;
            lsu_wen = 1'b1; lsu_wmask = 4'hF; lsu_wdata = 32'hFFFF_FFFF;
        end else begin
            lsu_req_valid = 1'b1; lsu_addr = v.addr;
            lsu_wen = v.wen; lsu_wdata = v.wdata; lsu_wmask = v.wmask;
        end
        wait_grant(ok);
        chk("vec_grant", {62'd0, ifu_req_ready, lsu_req_ready}, v.is_ifu ? 64'd2 : 64'd1);
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("vec_req", {mem_req_valid, busy, mem_addr}, {1'b1, 1'b1, v.addr});
        chk("vec_wen_mask", {mem_wen, mem_wmask}, v.is_ifu ? 5'd0 : {v.wen, v.wmask});
        if (!v.is_ifu && v.wen) chk("vec_wdata", mem_wdata, v.wdata);
        for (int i = 0; i < v.rdy_dly; i++) begin
            @(negedge clk);
            chk("vec_hold", {mem_req_valid, mem_addr, mem_wen, mem_wmask},
                {1'b1, v.addr, v.is_ifu ? 5'd0 : {v.wen, v.wmask}});
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("vec_resp_state", {mem_req_valid, busy}, 2'b01);
        mem_rsp_valid = 1'b1; mem_rdata = v.mrdata;
        chk("vec_no_early_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        chk("vec_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, v.is_ifu ? 2'b10 : 2'b01);
        chk("vec_rdata", v.is_ifu ? ifu_rdata : lsu_rdata, v.exp_rdata);
        chk("vec_err_busy", {v.is_ifu ? ifu_rsp_err : lsu_rsp_err, busy}, 2'b00);
        @(negedge clk);
        chk("vec_pulse_end", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        chk("vec_rdata_hold", v.is_ifu ? ifu_rdata : lsu_rdata, v.exp_rdata);
    endtask

    initial begin
        logic ok;
        logic bad;
        vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,         4'h0, 0, 32'h0000_0413, 32'h0000_0413};
        vecs[1] = '{1'b0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 0, 32'h1234_5678, 32'h0};
        vecs[2] = '{1'b0, 32'h8000_2004, 1'b0, 32'h0,         4'hF, 3, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0,         4'h0, 2, 32'h0010_0073, 32'h0010_0073};

        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", {63'd0, any_out()}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {63'd0, any_out()}, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fair alternation with both requesters held valid.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 4'h0;
        for (int k = 0; k < 4; k++) begin
            logic exp_ifu;
            exp_ifu = (k % 2 == 0);
            wait_grant(ok);
            chk("fair_grant", {62'd0, ifu_req_ready, lsu_req_ready}, exp_ifu ? 64'd2 : 64'd1);
            @(negedge clk);
            chk("fair_addr", mem_addr, exp_ifu ? 32'h8000_0100 : 32'h8000_0200);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1; mem_rdata = 32'h1000_0000 + k;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            chk("fair_route", {ifu_rsp_valid, lsu_rsp_valid}, exp_ifu ? 2'b10 : 2'b01);
            chk("fair_rdata", exp_ifu ? ifu_rdata : lsu_rdata, 32'h1000_0000 + k);
            if (k == 3) begin
                ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            end
        end

        // Memory never answers: abort 8 cycles after entering REQ.
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
        wait_grant(ok);
        chk("to_grant", {63'd0, ifu_req_ready}, 64'd1);
        bad = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ifu_req_valid = 1'b0;
            if (ifu_rsp_valid || lsu_rsp_valid || !busy || !mem_req_valid) bad = 1'b1;
        end
        chk("to_wait", {63'd0, bad}, 64'd0);
        @(negedge clk);
        chk("to_rsp", {ifu_rsp_valid, ifu_rsp_err, busy, mem_req_valid}, 4'b1100);
        chk("to_rdata", ifu_rdata, 32'h0);
        @(negedge clk);
        chk("to_pulse_end", {ifu_rsp_valid, ifu_rsp_err}, 2'b01);
        run_vec(vecs[0]);

        // Reset asserted while waiting in RESP.
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0400; lsu_wen = 1'b0;
        wait_grant(ok);
        chk("rst_grant", {63'd0, lsu_req_ready}, 64'd1);
        @(negedge clk);
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rst_in_resp", {mem_req_valid, busy}, 2'b01);
        rst = 1'b0;
        #1;
        chk("rst_async_clear", {63'd0, any_out()}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rst_no_rsp", {63'd0, any_out()}, 64'd0);

        // Stray response while idle.
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stray_ignored", {63'd0, any_out()}, 64'd0);
        @(negedge clk);
        chk("stray_still_idle", {63'd0, any_out()}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
